// File: rtl/apb2axi_wdata_packer_pkg.sv
// rtl/apb2axi_wdata_packer_pkg.sv - shared types and widths for the APB-to-AXI write data packer
package apb2axi_wdata_packer_pkg;

  localparam int APB_DATA_W             = 32;
  localparam int AXI_DATA_W             = 64;
  localparam int TAG_W                  = 4;
  localparam int MAX_BEATS_NUM          = 16;
  localparam int APB_WORDS_PER_AXI_BEAT = AXI_DATA_W / APB_DATA_W;
  localparam int WD_STRB_W              = APB_DATA_W / 8;
  localparam int AXI_STRB_W             = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUSH
  } packer_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [AXI_STRB_W-1:0] wstrb;
  } wr_entry_t;

  localparam int DATA_ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/apb2axi_wdata_packer_if.sv
// rtl/apb2axi_wdata_packer_if.sv - start, APB word, write-entry and status signals of the packer
interface apb2axi_wdata_packer_if;
  import apb2axi_wdata_packer_pkg::*;

  logic                  start_valid;
  logic                  start_ready;
  logic [TAG_W-1:0]      start_tag;
  logic [7:0]            start_len;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [APB_DATA_W-1:0] wd_data;
  logic [WD_STRB_W-1:0]  wd_strb;
  logic                  wr_valid;
  logic                  wr_ready;
  wr_entry_t             wr_entry;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  len_err;

  modport slave (
    input  start_valid, start_tag, start_len, wd_valid, wd_data, wd_strb, wr_ready, abort,
    output start_ready, wd_ready, wr_valid, wr_entry, busy, done, len_err
  );

  modport master (
    output start_valid, start_tag, start_len, wd_valid, wd_data, wd_strb, wr_ready, abort,
    input  start_ready, wd_ready, wr_valid, wr_entry, busy, done, len_err
  );

endinterface

// File: rtl/apb2axi_wdata_packer.sv
// rtl/apb2axi_wdata_packer.sv - packs 32-bit APB write words into 64-bit AXI W-channel entries
module apb2axi_wdata_packer
  import apb2axi_wdata_packer_pkg::*;
(
  input  logic                   pclk,
  input  logic                   presetn,
  apb2axi_wdata_packer_if.slave  bus
);

  localparam int WIDX_W = (APB_WORDS_PER_AXI_BEAT > 1) ? $clog2(APB_WORDS_PER_AXI_BEAT) : 1;

  packer_state_e         state;
  logic [TAG_W-1:0]      tag_q;
  logic [8:0]            beats_total;
  logic [8:0]            beat_cnt;
  logic [WIDX_W-1:0]     word_idx;
  logic [AXI_DATA_W-1:0] data_acc;
  logic [AXI_STRB_W-1:0] strb_acc;
  logic [AXI_DATA_W-1:0] data_ins;
  logic [AXI_STRB_W-1:0] strb_ins;
  wr_entry_t             entry_q;
  logic                  start_ready_q;
  logic                  wd_ready_q;
  logic                  wr_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  len_err_q;
  logic                  len_ok;
  logic                  last_word;
  logic                  beat_last;

  assign len_ok    = ({1'b0, bus.start_len} < 9'(MAX_BEATS_NUM));
  assign last_word = (word_idx == WIDX_W'(APB_WORDS_PER_AXI_BEAT - 1));
  assign beat_last = (beat_cnt == beats_total - 9'd1);

  // Word 0 lands in the low lane; the current word is merged into the accumulators
  always_comb begin
    data_ins = data_acc;
    strb_ins = strb_acc;
    data_ins[APB_DATA_W * int'(word_idx) +: APB_DATA_W] = bus.wd_data;
    strb_ins[WD_STRB_W * int'(word_idx) +: WD_STRB_W]   = bus.wd_strb;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state         <= ST_IDLE;
      tag_q         <= '0;
      beats_total   <= '0;
      beat_cnt      <= '0;
      word_idx      <= '0;
      data_acc      <= '0;
      strb_acc      <= '0;
      entry_q       <= '0;
      start_ready_q <= 1'b1;
      wd_ready_q    <= 1'b0;
      wr_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state         <= ST_IDLE;
        wr_valid_q    <= 1'b0;
        wd_ready_q    <= 1'b0;
        start_ready_q <= 1'b1;
        busy_q        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start_valid && !bus.abort) begin
              if (len_ok) begin
                tag_q         <= bus.start_tag;
                beats_total   <= {1'b0, bus.start_len} + 9'd1;
                beat_cnt      <= '0;
                word_idx      <= '0;
                data_acc      <= '0;
                strb_acc      <= '0;
                state         <= ST_COLLECT;
                wd_ready_q    <= 1'b1;
                start_ready_q <= 1'b0;
                busy_q        <= 1'b1;
              end else begin
                len_err_q <= 1'b1;
              end
            end
          end
          ST_COLLECT: begin
            if (bus.wd_valid) begin
              data_acc <= data_ins;
              strb_acc <= strb_ins;
              if (last_word) begin
                entry_q    <= '{tag: tag_q, data: data_ins, last: beat_last, wstrb: strb_ins};
                wr_valid_q <= 1'b1;
                wd_ready_q <= 1'b0;
                state      <= ST_PUSH;
              end else begin
                word_idx <= word_idx + WIDX_W'(1);
              end
            end
          end
          ST_PUSH: begin
            if (bus.wr_ready) begin
              wr_valid_q <= 1'b0;
              if (entry_q.last) begin
                state         <= ST_IDLE;
                done_q        <= 1'b1;
                start_ready_q <= 1'b1;
                busy_q        <= 1'b0;
              end else begin
                beat_cnt   <= beat_cnt + 9'd1;
                word_idx   <= '0;
                data_acc   <= '0;
                strb_acc   <= '0;
                state      <= ST_COLLECT;
                wd_ready_q <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.wd_ready    = wd_ready_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_entry    = entry_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.len_err     = len_err_q;

endmodule
